cpu6502_ldst_core: RTL

//   Parametrised 6502-compatible load/store/transfer core: LDA/LDX/LDY, STA/STX/STY, register transfers and INC/DEC X/Y.

---
 rtl/cpu6502_pkg.sv | 45 ++++
 rtl/cpu6502_decode.sv | 53 +++++
 rtl/cpu6502_ldst_core.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/cpu6502_pkg.sv
// Shared types and opcode constants for the 6502 load/store core.
package cpu6502_pkg;

  // AIDX is kept in the encoding for the full-CPU roadmap; this core never enters it.
  typedef enum logic [3:0] {
    S_FETCH, S_IMPL, S_IMM, S_ZP, S_ZPX, S_ABSL, S_ABSH, S_AIDX, S_FIX, S_MEM
  } state_e;

  typedef enum logic [2:0] {M_IMPL, M_IMM, M_ZP, M_ZPI, M_ABS, M_ABSI} mode_e;
  typedef enum logic [1:0] {R_A, R_X, R_Y} reg_e;
  typedef enum logic [2:0] {OP_NOP, OP_LD, OP_ST, OP_XFER, OP_INC, OP_DEC} op_e;

  typedef struct packed {
    mode_e mode;
    op_e   op;
    reg_e  src;
    reg_e  dst;
    reg_e  idx;
  } dec_t;

  localparam logic [7:0] OPC_LDA_IMM = 8'hA9, OPC_LDA_ZP = 8'hA5, OPC_LDA_ZPX = 8'hB5;
  localparam logic [7:0] OPC_LDA_ABS = 8'hAD, OPC_LDA_ABX = 8'hBD, OPC_LDA_ABY = 8'hB9;
  localparam logic [7:0] OPC_LDX_IMM = 8'hA2, OPC_LDX_ZP = 8'hA6, OPC_LDX_ZPY = 8'hB6;
  localparam logic [7:0] OPC_LDX_ABS = 8'hAE, OPC_LDX_ABY = 8'hBE;
  localparam logic [7:0] OPC_LDY_IMM = 8'hA0, OPC_LDY_ZP = 8'hA4, OPC_LDY_ZPX = 8'hB4;
  localparam logic [7:0] OPC_LDY_ABS = 8'hAC, OPC_LDY_ABX = 8'hBC;
  localparam logic [7:0] OPC_STA_ZP  = 8'h85, OPC_STA_ZPX = 8'h95, OPC_STA_ABS = 8'h8D;
  localparam logic [7:0] OPC_STA_ABX = 8'h9D, OPC_STA_ABY = 8'h99;
  localparam logic [7:0] OPC_STX_ZP  = 8'h86, OPC_STX_ZPY = 8'h96, OPC_STX_ABS = 8'h8E;
  localparam logic [7:0] OPC_STY_ZP  = 8'h84, OPC_STY_ZPX = 8'h94, OPC_STY_ABS = 8'h8C;
  localparam logic [7:0] OPC_TAX = 8'hAA, OPC_TXA = 8'h8A, OPC_TAY = 8'hA8, OPC_TYA = 8'h98;
  localparam logic [7:0] OPC_INX = 8'hE8, OPC_INY = 8'hC8, OPC_DEX = 8'hCA, OPC_DEY = 8'h88;
  localparam logic [7:0] OPC_NOP = 8'hEA;

  function automatic dec_t mk(mode_e mode, op_e op, reg_e src, reg_e dst, reg_e idx);
    dec_t d;
    d.mode = mode;
    d.op   = op;
    d.src  = src;
    d.dst  = dst;
    d.idx  = idx;
    return d;
  endfunction

endpackage

// File: rtl/cpu6502_decode.sv
// Opcode decoder: addressing mode, operation class and register selects.
module cpu6502_decode
  import cpu6502_pkg::*;
(
  input  logic [7:0] opcode,
  output dec_t       dec
);

  // Table lookup; anything not listed behaves as a 1-byte implied NOP.
  always_comb begin
    dec = mk(M_IMPL, OP_NOP, R_A, R_A, R_X);
    case (opcode)
      OPC_LDA_IMM: dec = mk(M_IMM,  OP_LD, R_A, R_A, R_X);
      OPC_LDA_ZP:  dec = mk(M_ZP,   OP_LD, R_A, R_A, R_X);
      OPC_LDA_ZPX: dec = mk(M_ZPI,  OP_LD, R_A, R_A, R_X);
      OPC_LDA_ABS: dec = mk(M_ABS,  OP_LD, R_A, R_A, R_X);
      OPC_LDA_ABX: dec = mk(M_ABSI, OP_LD, R_A, R_A, R_X);
      OPC_LDA_ABY: dec = mk(M_ABSI, OP_LD, R_A, R_A, R_Y);
      OPC_LDX_IMM: dec = mk(M_IMM,  OP_LD, R_X, R_X, R_Y);
      OPC_LDX_ZP:  dec = mk(M_ZP,   OP_LD, R_X, R_X, R_Y);
      OPC_LDX_ZPY: dec = mk(M_ZPI,  OP_LD, R_X, R_X, R_Y);
      OPC_LDX_ABS: dec = mk(M_ABS,  OP_LD, R_X, R_X, R_Y);
      OPC_LDX_ABY: dec = mk(M_ABSI, OP_LD, R_X, R_X, R_Y);
      OPC_LDY_IMM: dec = mk(M_IMM,  OP_LD, R_Y, R_Y, R_X);
      OPC_LDY_ZP:  dec = mk(M_ZP,   OP_LD, R_Y, R_Y, R_X);
      OPC_LDY_ZPX: dec = mk(M_ZPI,  OP_LD, R_Y, R_Y, R_X);
      OPC_LDY_ABS: dec = mk(M_ABS,  OP_LD, R_Y, R_Y, R_X);
      OPC_LDY_ABX: dec = mk(M_ABSI, OP_LD, R_Y, R_Y, R_X);
      OPC_STA_ZP:  dec = mk(M_ZP,   OP_ST, R_A, R_A, R_X);
      OPC_STA_ZPX: dec = mk(M_ZPI,  OP_ST, R_A, R_A, R_X);
      OPC_STA_ABS: dec = mk(M_ABS,  OP_ST, R_A, R_A, R_X);
      OPC_STA_ABX: dec = mk(M_ABSI, OP_ST, R_A, R_A, R_X);
      OPC_STA_ABY: dec = mk(M_ABSI, OP_ST, R_A, R_A, R_Y);
      OPC_STX_ZP:  dec = mk(M_ZP,   OP_ST, R_X, R_X, R_Y);
      OPC_STX_ZPY: dec = mk(M_ZPI,  OP_ST, R_X, R_X, R_Y);
      OPC_STX_ABS: dec = mk(M_ABS,  OP_ST, R_X, R_X, R_Y);
      OPC_STY_ZP:  dec = mk(M_ZP,   OP_ST, R_Y, R_Y, R_X);
      OPC_STY_ZPX: dec = mk(M_ZPI,  OP_ST, R_Y, R_Y, R_X);
      OPC_STY_ABS: dec = mk(M_ABS,  OP_ST, R_Y, R_Y, R_X);
      OPC_TAX:     dec = mk(M_IMPL, OP_XFER, R_A, R_X, R_X);
      OPC_TXA:     dec = mk(M_IMPL, OP_XFER, R_X, R_A, R_X);
      OPC_TAY:     dec = mk(M_IMPL, OP_XFER, R_A, R_Y, R_X);
      OPC_TYA:     dec = mk(M_IMPL, OP_XFER, R_Y, R_A, R_X);
      OPC_INX:     dec = mk(M_IMPL, OP_INC, R_X, R_X, R_X);
      OPC_INY:     dec = mk(M_IMPL, OP_INC, R_Y, R_Y, R_X);
      OPC_DEX:     dec = mk(M_IMPL, OP_DEC, R_X, R_X, R_X);
      OPC_DEY:     dec = mk(M_IMPL, OP_DEC, R_Y, R_Y, R_X);
      OPC_NOP:     dec = mk(M_IMPL, OP_NOP, R_A, R_A, R_X);
      default:     dec = mk(M_IMPL, OP_NOP, R_A, R_A, R_X);
    endcase
  end

endmodule

// File: rtl/cpu6502_ldst_core.sv
// 6502 load/store/transfer core with cycle-accurate bus sequencing and RDY stall.
// The write-data port is named dout because "do" is a SystemVerilog keyword.
module cpu6502_ldst_core
  import cpu6502_pkg::*;
#(
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rdy,
  input  logic [7:0]        di,
  output logic [7:0]        dout,
  output logic [ADDR_W-1:0] ab,
  output logic              we,
  output logic              sync,
  output logic [7:0]        dbg_a,
  output logic [7:0]        dbg_x,
  output logic [7:0]        dbg_y,
  output logic              flag_n,
  output logic              flag_z
);

  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PAGE = ADDR_W'(16'h0100);

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt, pc_inc, ab_nxt;
  logic [7:0]        ir, ir_nxt, lo, lo_nxt, dout_nxt;
  logic [7:0]        a, x, y, src_val, idx_val, zp_idx, wr_val;
  logic [8:0]        abs_sum;
  logic              we_nxt, cy, cy_nxt, n, z, wr_en;
  dec_t              dec;

  // In FETCH the opcode is still on di; afterwards it lives in ir.
  cpu6502_decode u_dec (
    .opcode (state == S_FETCH ? di : ir),
    .dec    (dec)
  );

  assign src_val = (dec.src == R_A) ? a : (dec.src == R_X) ? x : y;
  assign idx_val = (dec.idx == R_Y) ? y : x;
  assign zp_idx  = lo + idx_val;
  assign abs_sum = {1'b0, lo} + {1'b0, (dec.mode == M_ABSI) ? idx_val : 8'h00};
  assign pc_inc  = pc + ONE;

  // Next-state, bus and register-write decisions for the current cycle.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ab_nxt    = ab;
    we_nxt    = 1'b0;
    dout_nxt  = dout;
    ir_nxt    = ir;
    lo_nxt    = lo;
    cy_nxt    = cy;
    wr_en     = 1'b0;
    wr_val    = di;
    case (state)
      S_FETCH: begin
        ir_nxt = di;
        pc_nxt = pc_inc;
        ab_nxt = pc_inc;
        case (dec.mode)
          M_IMPL:      state_nxt = S_IMPL;
          M_IMM:       state_nxt = S_IMM;
          M_ZP, M_ZPI: state_nxt = S_ZP;
          default:     state_nxt = S_ABSL;
        endcase
      end
      S_IMPL: begin
        wr_en = (dec.op == OP_XFER) || (dec.op == OP_INC) || (dec.op == OP_DEC);
        case (dec.op)
          OP_INC:  wr_val = src_val + 8'd1;
          OP_DEC:  wr_val = src_val - 8'd1;
          default: wr_val = src_val;
        endcase
        ab_nxt    = pc;
        state_nxt = S_FETCH;
      end
      S_IMM: begin
        wr_en     = (dec.op == OP_LD);
        pc_nxt    = pc_inc;
        ab_nxt    = pc_inc;
        state_nxt = S_FETCH;
      end
      S_ZP: begin
        lo_nxt    = di;
        pc_nxt    = pc_inc;
        ab_nxt    = ADDR_W'(di);
        state_nxt = (dec.mode == M_ZPI) ? S_ZPX : S_MEM;
      end
      S_ZPX: begin
        // Index add stays inside page zero.
        ab_nxt    = ADDR_W'(zp_idx);
        state_nxt = S_MEM;
      end
      S_ABSL: begin
        lo_nxt    = di;
        pc_nxt    = pc_inc;
        ab_nxt    = pc_inc;
        state_nxt = S_ABSH;
      end
      S_ABSH: begin
        // High byte not yet carry-corrected; FIX repairs it when needed.
        pc_nxt    = pc_inc;
        cy_nxt    = abs_sum[8];
        ab_nxt    = ADDR_W'({di, abs_sum[7:0]});
        state_nxt = (dec.mode == M_ABSI && (dec.op == OP_ST || abs_sum[8])) ? S_FIX : S_MEM;
      end
      S_FIX: begin
        ab_nxt    = ab + (cy ? PAGE : '0);
        state_nxt = S_MEM;
      end
      S_MEM: begin
        wr_en     = (dec.op == OP_LD);
        ab_nxt    = pc;
        state_nxt = S_FETCH;
      end
      default: begin
        ab_nxt    = pc;
        state_nxt = S_FETCH;
      end
    endcase
    // Stores drive the bus for the whole MEM cycle.
    if (state_nxt == S_MEM && dec.op == OP_ST) begin
      we_nxt   = 1'b1;
      dout_nxt = src_val;
    end
  end

  // State register; rdy low freezes everything, reset overrides it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
      ab    <= RESET_PC;
      we    <= 1'b0;
      dout  <= 8'h00;
      ir    <= OPC_NOP;
      lo    <= 8'h00;
      cy    <= 1'b0;
      a     <= 8'h00;
      x     <= 8'h00;
      y     <= 8'h00;
      n     <= 1'b0;
      z     <= 1'b0;
    end else if (rdy) begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ab    <= ab_nxt;
      we    <= we_nxt;
      dout  <= dout_nxt;
      ir    <= ir_nxt;
      lo    <= lo_nxt;
      cy    <= cy_nxt;
      if (wr_en) begin
        case (dec.dst)
          R_A:     a <= wr_val;
          R_X:     x <= wr_val;
          default: y <= wr_val;
        endcase
        n <= wr_val[7];
        z <= (wr_val == 8'h00);
      end
    end
  end

  assign sync   = (state == S_FETCH);
  assign dbg_a  = a;
  assign dbg_x  = x;
  assign dbg_y  = y;
  assign flag_n = n;
  assign flag_z = z;

endmodule
